// File: rtl/lsu_mem_initiator_pkg.sv
// Shared definitions for the LSU memory-port initiator: size codes, FSM states
// and the alignment rule used to reject misaligned accesses.
package lsu_mem_initiator_pkg;

  localparam int unsigned MASK_W = 8;

  localparam logic [1:0] SZ_B   = 2'd0;
  localparam logic [1:0] SZ_H   = 2'd1;
  localparam logic [1:0] SZ_W   = 2'd2;
  localparam logic [1:0] SZ_RSV = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Reserved size is always treated as misaligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      SZ_W:    return off != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_initiator_align.sv
// Byte-lane steering: store mask/data placement and load extraction/extension.
// Purely combinational so a cached LSU can reuse it unchanged.
module lsu_lane_align
  import lsu_mem_initiator_pkg::*;
(
  input  logic [1:0]        off,
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic [31:0]       store_data,
  input  logic [31:0]       load_word,
  output logic [MASK_W-1:0] wmask,
  output logic [31:0]       wdata,
  output logic [31:0]       load_data
);

  logic [3:0]  base;
  logic [31:0] shifted;

  always_comb begin
    base = 4'b1111;
    case (size)
      SZ_B:    base = 4'b0001;
      SZ_H:    base = 4'b0011;
      default: base = 4'b1111;
    endcase

    // Lanes shifted past byte 3 fall off; upper mask nibble is always zero.
    wmask      = '0;
    wmask[3:0] = base << off;
    wdata      = store_data << {off, 3'b000};

    shifted = load_word >> {off, 3'b000};
    case (size)
      SZ_B:    load_data = {{24{sext & shifted[7]}},  shifted[7:0]};
      SZ_H:    load_data = {{16{sext & shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Single-outstanding load/store initiator for the DPI physical-memory port.
// IDLE -> ISSUE -> WAIT -> RESP, or IDLE -> RESP directly on a rejected access.
module lsu_mem_initiator
  import lsu_mem_initiator_pkg::*;
#(
  parameter int unsigned ADDR_W          = 32,
  parameter bit          ERR_ON_MISALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_sext,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_valid,
  output logic [31:0]       mem_raddr,
  input  logic [31:0]       mem_rdata,
  output logic              mem_wen,
  output logic [31:0]       mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic [MASK_W-1:0] mem_wmask
);

  state_t            state;
  logic [1:0]        off_q;
  logic [1:0]        size_q;
  logic              sext_q;
  logic              store_q;

  logic              accept;
  logic              misalign;
  logic [ADDR_W-1:0] aligned_addr;
  logic [1:0]        sel_off;
  logic [1:0]        sel_size;
  logic              sel_sext;
  logic [MASK_W-1:0] align_wmask;
  logic [31:0]       align_wdata;
  logic [31:0]       align_load;

  assign accept       = req_valid && req_ready;
  assign misalign     = ERR_ON_MISALIGN && is_misaligned(req_size, req_addr[1:0]);
  assign aligned_addr = {req_addr[ADDR_W-1:2], 2'b00};

  // The aligner sees the live request while idle (store placement at accept)
  // and the latched request afterwards (load extraction in WAIT).
  assign sel_off  = (state == ST_IDLE) ? req_addr[1:0] : off_q;
  assign sel_size = (state == ST_IDLE) ? req_size      : size_q;
  assign sel_sext = (state == ST_IDLE) ? req_sext      : sext_q;

  lsu_lane_align u_align (
    .off        (sel_off),
    .size       (sel_size),
    .sext       (sel_sext),
    .store_data (req_wdata),
    .load_word  (mem_rdata),
    .wmask      (align_wmask),
    .wdata      (align_wdata),
    .load_data  (align_load)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_valid  <= 1'b0;
      mem_wen    <= 1'b0;
      mem_raddr  <= '0;
      mem_waddr  <= '0;
      mem_wdata  <= '0;
      mem_wmask  <= '0;
      off_q      <= '0;
      size_q     <= '0;
      sext_q     <= 1'b0;
      store_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            off_q     <= req_addr[1:0];
            size_q    <= req_size;
            sext_q    <= req_sext;
            store_q   <= req_store;
            if (misalign) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
              state      <= ST_RESP;
            end else begin
              mem_valid <= 1'b1;
              mem_wen   <= req_store;
              mem_raddr <= 32'(aligned_addr);
              mem_waddr <= 32'(aligned_addr);
              mem_wdata <= align_wdata;
              mem_wmask <= align_wmask;
              resp_err  <= 1'b0;
              state     <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          mem_valid <= 1'b0;
          mem_wen   <= 1'b0;
          state     <= ST_WAIT;
        end
        ST_WAIT: begin
          resp_rdata <= store_q ? '0 : align_load;
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
